qam_symbol_mapper: RTL and testbench

Parametrised streaming QAM mapper feeding the 16-point FFT input buffer. It replaces the fixed QAM4 constellation table with a bit-serial mapper that supports QPSK and 16-QAM, selectable per frame. Bits are accepted on a valid/ready handshake, and one signed fixed-point complex symbol is emitted per handshake. Symbols are indexed within frames of FRAME_LEN symbols, so the FFT loader can place each one in its bin.

---
 rtl/qam_symbol_mapper.sv | 127 ++++++++++++
 tb/tb_qam_symbol_mapper.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/qam_symbol_mapper.sv
// Bit-serial QPSK / 16-QAM mapper with a valid/ready handshake on both sides.
// Emits one fixed-point complex symbol per handshake, indexed within its frame.
module qam_symbol_mapper #(
  parameter  int WORD_SIZE = 16,
  parameter  int FRAC_BITS = 8,
  parameter  int FRAME_LEN = 16,
  localparam int IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_mode,
  input  logic                 i_bit_valid,
  input  logic                 i_bit,
  output logic                 o_bit_ready,
  output logic                 o_sym_valid,
  input  logic                 i_sym_ready,
  output logic [WORD_SIZE-1:0] o_sym_re,
  output logic [WORD_SIZE-1:0] o_sym_im,
  output logic [IDX_W-1:0]     o_sym_idx,
  output logic                 o_frame_last,
  output logic                 o_mode
);

  typedef enum logic {COLLECT, HOLD} state_t;

  localparam real SCALE     = 2.0 ** FRAC_BITS;
  localparam int  LVL_QPSK  = $rtoi(0.7071 * SCALE + 0.5);
  localparam int  LVL_INNER = $rtoi(0.3162 * SCALE + 0.5);
  localparam int  LVL_OUTER = $rtoi(0.9487 * SCALE + 0.5);

  localparam logic [WORD_SIZE-1:0] MAG_QPSK  = WORD_SIZE'(LVL_QPSK);
  localparam logic [WORD_SIZE-1:0] MAG_INNER = WORD_SIZE'(LVL_INNER);
  localparam logic [WORD_SIZE-1:0] MAG_OUTER = WORD_SIZE'(LVL_OUTER);

  state_t                 state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [2:0]             shreg_q, shreg_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   mode_q, mode_d;
  logic [WORD_SIZE-1:0]   re_q, re_d;
  logic [WORD_SIZE-1:0]   im_q, im_d;

  logic       frame_start;
  logic       cur_mode;
  logic [1:0] last_cnt;
  logic       bit_xfer;

  function automatic logic [WORD_SIZE-1:0] signed_lvl(input logic neg,
                                                      input logic [WORD_SIZE-1:0] mag);
    return neg ? -mag : mag;
  endfunction

  // The frame's first bit must already use the incoming mode to size the symbol.
  assign frame_start = (idx_q == '0) && (cnt_q == 2'd0);
  assign cur_mode    = frame_start ? i_mode : mode_q;
  assign last_cnt    = cur_mode ? 2'd3 : 2'd1;

  assign o_bit_ready = (state_q == COLLECT) && !i_rst;
  assign bit_xfer    = i_bit_valid && o_bit_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    re_d    = re_q;
    im_d    = im_q;
    case (state_q)
      COLLECT: begin
        if (bit_xfer) begin
          if (frame_start) mode_d = i_mode;
          if (cnt_q == last_cnt) begin
            // shreg holds earlier bits newest-first: QPSK b0 in [0]; 16-QAM {b0,b1,b2}.
            if (cur_mode) begin
              re_d = signed_lvl(shreg_q[2], shreg_q[1] ? MAG_INNER : MAG_OUTER);
              im_d = signed_lvl(shreg_q[0], i_bit ? MAG_INNER : MAG_OUTER);
            end else begin
              re_d = signed_lvl(shreg_q[0], MAG_QPSK);
              im_d = signed_lvl(i_bit, MAG_QPSK);
            end
            state_d = HOLD;
          end else begin
            shreg_d = {shreg_q[1:0], i_bit};
            cnt_d   = cnt_q + 2'd1;
          end
        end
      end
      HOLD: begin
        if (i_sym_ready) begin
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = 2'd0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      shreg_q <= '0;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      re_q    <= re_d;
      im_q    <= im_d;
    end
  end

  assign o_sym_valid  = (state_q == HOLD);
  assign o_sym_re     = re_q;
  assign o_sym_im     = im_q;
  assign o_sym_idx    = idx_q;
  assign o_mode       = mode_q;
  assign o_frame_last = o_sym_valid && (idx_q == IDX_W'(FRAME_LEN - 1));

endmodule

// File: tb/tb_qam_symbol_mapper.sv
// Self-checking bench for qam_symbol_mapper against a constellation-table model.
module tb_qam_symbol_mapper;
  localparam int WS = 16;
  localparam int FL = 16;
  localparam int IW = $clog2(FL);

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_mode = 1'b0;
  logic          i_bit_valid = 1'b0;
  logic          i_bit = 1'b0;
  logic          o_bit_ready;
  logic          o_sym_valid;
  logic          i_sym_ready = 1'b0;
  logic [WS-1:0] o_sym_re;
  logic [WS-1:0] o_sym_im;
  logic [IW-1:0] o_sym_idx;
  logic          o_frame_last;
  logic          o_mode;

  int tests = 0;
  int fails = 0;
  int exp_idx = 0;
  logic mdl_mode = 1'b0;
  int cycle = 0;

  qam_symbol_mapper #(.WORD_SIZE(WS), .FRAC_BITS(8), .FRAME_LEN(FL)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_mode(i_mode), .i_bit_valid(i_bit_valid),
    .i_bit(i_bit), .o_bit_ready(o_bit_ready), .o_sym_valid(o_sym_valid),
    .i_sym_ready(i_sym_ready), .o_sym_re(o_sym_re), .o_sym_im(o_sym_im),
    .o_sym_idx(o_sym_idx), .o_frame_last(o_frame_last), .o_mode(o_mode)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cycle <= cycle + 1;

  // Constellation point from sign bit and magnitude-select bit.
  function automatic logic [WS-1:0] level(input logic qam, input logic s, input logic m);
    int mag;
    mag = qam ? (m ? 81 : 243) : 181;
    return WS'(s ? -mag : mag);
  endfunction

  task automatic push_bit(input logic b, input logic gap);
    int t;
    t = 0;
    if (gap) begin
      i_bit_valid = 1'b0;
      i_bit = 1'($urandom);
      @(negedge i_clk);
    end
    i_bit_valid = 1'b1;
    i_bit = b;
    while (!o_bit_ready && t < 100) begin
      @(negedge i_clk);
      t++;
    end
    if (t >= 100) begin
      tests++; fails++;
      $display("FAIL bit_ready_timeout: o_bit_ready=%0b required 1", o_bit_ready);
    end
    @(negedge i_clk);
    i_bit_valid = 1'b0;
  endtask

  task automatic send_symbol(input logic [3:0] nib, input logic gaps, input int rdy_delay);
    logic b[4];
    int bps;
    logic [WS-1:0] er, ei;
    logic [WS-1:0] hre, him;
    if (exp_idx == 0) mdl_mode = i_mode;
    bps = mdl_mode ? 4 : 2;
    for (int k = 0; k < 4; k++) b[k] = nib[3-k];
    for (int k = 0; k < bps; k++) push_bit(b[k], gaps && ($urandom_range(0, 3) == 0));
    if (mdl_mode) begin
      er = level(1'b1, b[0], b[1]);
      ei = level(1'b1, b[2], b[3]);
    end else begin
      er = level(1'b0, b[0], 1'b0);
      ei = level(1'b0, b[1], 1'b0);
    end
    tests++;
    if (o_sym_valid !== 1'b1) begin fails++; $display("FAIL sym_valid: got %0b required 1", o_sym_valid); end
    tests++;
    if (o_sym_re !== er) begin fails++; $display("FAIL sym_re idx%0d: got %h required %h", exp_idx, o_sym_re, er); end
    tests++;
    if (o_sym_im !== ei) begin fails++; $display("FAIL sym_im idx%0d: got %h required %h", exp_idx, o_sym_im, ei); end
    tests++;
    if (o_sym_idx !== IW'(exp_idx)) begin fails++; $display("FAIL sym_idx: got %0d required %0d", o_sym_idx, exp_idx); end
    tests++;
    if (o_frame_last !== (exp_idx == FL - 1)) begin
      fails++; $display("FAIL frame_last idx%0d: got %0b required %0b", exp_idx, o_frame_last, exp_idx == FL - 1);
    end
    tests++;
    if (o_mode !== mdl_mode) begin fails++; $display("FAIL o_mode idx%0d: got %0b required %0b", exp_idx, o_mode, mdl_mode); end
    tests++;
    if (o_bit_ready !== 1'b0) begin fails++; $display("FAIL hold_ready: got %0b required 0", o_bit_ready); end
    hre = o_sym_re;
    him = o_sym_im;
    for (int c = 0; c < rdy_delay; c++) begin
      i_bit_valid = 1'b1;
      i_bit = 1'($urandom);
      @(negedge i_clk);
      tests++;
      if (o_bit_ready !== 1'b0 || o_sym_valid !== 1'b1 || o_sym_re !== hre || o_sym_im !== him
          || o_sym_idx !== IW'(exp_idx)) begin
        fails++;
        $display("FAIL hold_stable cyc%0d: ready=%0b valid=%0b re=%h im=%h idx=%0d required 0 1 %h %h %0d",
                 c, o_bit_ready, o_sym_valid, o_sym_re, o_sym_im, o_sym_idx, hre, him, exp_idx);
      end
    end
    i_sym_ready = 1'b1;
    @(negedge i_clk);
    i_sym_ready = 1'b0;
    i_bit_valid = 1'b0;
    tests++;
    if (o_sym_valid !== 1'b0 || o_frame_last !== 1'b0) begin
      fails++; $display("FAIL after_consume: valid=%0b last=%0b required 0 0", o_sym_valid, o_frame_last);
    end
    exp_idx = (exp_idx + 1) % FL;
  endtask

  task automatic pad_frame();
    while (exp_idx != 0) send_symbol(4'($urandom), 1'b0, 0);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_bit_valid = 1'b1; i_bit = 1'b1; i_mode = 1'b1;
    repeat (2) @(negedge i_clk);
    tests++;
    if (o_bit_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %0b required 0", o_bit_ready); end
    tests++;
    if (o_sym_valid !== 1'b0 || o_sym_re !== '0 || o_sym_im !== '0 || o_sym_idx !== '0
        || o_frame_last !== 1'b0 || o_mode !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%0b re=%h im=%h idx=%0d last=%0b mode=%0b required all 0",
               o_sym_valid, o_sym_re, o_sym_im, o_sym_idx, o_frame_last, o_mode);
    end
    i_rst = 1'b0; i_bit_valid = 1'b0; i_mode = 1'b0;
    #1;
    tests++;
    if (o_bit_ready !== 1'b1 || o_sym_idx !== '0) begin
      fails++; $display("FAIL release: ready=%0b idx=%0d required 1 0", o_bit_ready, o_sym_idx);
    end
    exp_idx = 0;
  endtask

  task automatic test_qpsk_sweep();
    int c0;
    i_mode = 1'b0;
    c0 = cycle;
    send_symbol(4'b0000, 1'b0, 0);
    send_symbol(4'b0100, 1'b0, 0);
    send_symbol(4'b1100, 1'b0, 0);
    send_symbol(4'b1000, 1'b0, 0);
    tests++;
    if (cycle - c0 !== 12) begin fails++; $display("FAIL qpsk_throughput: got %0d cycles required 12", cycle - c0); end
    pad_frame();
  endtask

  task automatic test_qam16_all();
    int c0;
    i_mode = 1'b1;
    c0 = cycle;
    for (int n = 0; n < 16; n++) send_symbol(4'(n), 1'b0, 0);
    tests++;
    if (cycle - c0 !== 80) begin fails++; $display("FAIL qam16_throughput: got %0d cycles required 80", cycle - c0); end
    send_symbol(4'b1011, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    i_mode = 1'b1;
    send_symbol(4'b0110, 1'b0, 5);
    send_symbol(4'b1001, 1'b0, 0);
    pad_frame();
  endtask

  task automatic test_mode_change();
    i_mode = 1'b0;
    for (int s = 0; s < 3; s++) send_symbol(4'($urandom), 1'b0, 0);
    i_mode = 1'b1;
    for (int s = 3; s < FL; s++) send_symbol(4'($urandom), 1'b0, 0);
    send_symbol(4'b0101, 1'b0, 0);
    send_symbol(4'b1110, 1'b0, 0);
    pad_frame();
  endtask

  task automatic test_reset_mid();
    i_mode = 1'b1;
    for (int k = 0; k < 3; k++) push_bit(1'($urandom), 1'b0);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    exp_idx = 0;
    #1;
    tests++;
    if (o_sym_valid !== 1'b0 || o_sym_idx !== '0 || o_mode !== 1'b0) begin
      fails++; $display("FAIL reset_mid: valid=%0b idx=%0d mode=%0b required 0 0 0", o_sym_valid, o_sym_idx, o_mode);
    end
    send_symbol(4'b0011, 1'b0, 0);
    pad_frame();
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      for (int s = 0; s < FL; s++) begin
        i_mode = 1'($urandom);
        send_symbol(4'($urandom), 1'b1, $urandom_range(0, 2));
      end
    end
  endtask

  initial begin
    @(negedge i_clk);
    test_reset();
    test_qpsk_sweep();
    test_qam16_all();
    test_backpressure();
    test_mode_change();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
